// File: rtl/ddr3_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the DDR3 controller user port.
// Port A is the write port and port B is the read port. One burst is in flight at a time:
// the request is granted, the controller command is issued, then beats are steered.
module ddr3_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [LEN_WIDTH-1:0]  a_len,
    output logic                  a_gnt,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  a_wvalid,
    output logic                  a_wready,
    output logic                  a_done,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [LEN_WIDTH-1:0]  b_len,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  b_done,
    output logic                  ctl_cmd_valid,
    input  logic                  ctl_cmd_ready,
    output logic                  ctl_cmd_we,
    output logic [ADDR_WIDTH-1:0] ctl_cmd_addr,
    output logic [LEN_WIDTH-1:0]  ctl_cmd_len,
    output logic [DATA_WIDTH-1:0] ctl_wdata,
    output logic                  ctl_wvalid,
    input  logic                  ctl_wready,
    input  logic [DATA_WIDTH-1:0] ctl_rdata,
    input  logic                  ctl_rvalid,
    output logic                  busy,
    output logic                  proto_err
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic                  last_b_q, last_b_n;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_n;
    logic                  cmd_valid_n;
    logic                  cmd_we_n;
    logic [ADDR_WIDTH-1:0] cmd_addr_n;
    logic [LEN_WIDTH-1:0]  cmd_len_n;
    logic                  a_gnt_n, b_gnt_n, a_done_n, b_done_n;
    logic                  pick_a, pick_b;
    logic                  in_wdata, in_rdata;
    logic                  beat_w, beat_r;
    logic [LEN_WIDTH-1:0]  last_beat;

    // Round-robin pick: a lone requester wins, on a tie the port not served last wins
    assign pick_a = a_req & (~b_req | last_b_q);
    assign pick_b = b_req & (~a_req | ~last_b_q);

    // Index of the final beat; only used in data states where the latched length is non-zero
    assign last_beat = ctl_cmd_len - LEN_ONE;

    // Data-phase passthroughs, forced to zero outside their own state
    assign in_wdata   = (state_q == WDATA);
    assign in_rdata   = (state_q == RDATA);
    assign ctl_wdata  = in_wdata ? a_wdata : '0;
    assign ctl_wvalid = in_wdata & a_wvalid;
    assign a_wready   = in_wdata & ctl_wready;
    assign b_rdata    = in_rdata ? ctl_rdata : '0;
    assign b_rvalid   = in_rdata & ctl_rvalid;
    assign beat_w     = in_wdata & a_wvalid & ctl_wready;
    assign beat_r     = in_rdata & ctl_rvalid;

    // Next-state and next-output decode
    always_comb begin
        state_n     = state_q;
        last_b_n    = last_b_q;
        cnt_n       = cnt_q;
        cmd_valid_n = ctl_cmd_valid;
        cmd_we_n    = ctl_cmd_we;
        cmd_addr_n  = ctl_cmd_addr;
        cmd_len_n   = ctl_cmd_len;
        a_gnt_n     = 1'b0;
        b_gnt_n     = 1'b0;
        a_done_n    = 1'b0;
        b_done_n    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_a || pick_b) begin
                    state_n     = CMD;
                    last_b_n    = pick_b;
                    cmd_we_n    = pick_a;
                    cmd_addr_n  = pick_a ? a_addr : b_addr;
                    cmd_len_n   = pick_a ? a_len : b_len;
                    cmd_valid_n = pick_a ? (a_len != '0) : (b_len != '0);
                    a_gnt_n     = pick_a;
                    b_gnt_n     = pick_b;
                end
            end
            CMD: begin
                if (ctl_cmd_len == '0) begin
                    // Zero-length burst: acknowledged without touching the controller
                    state_n  = IDLE;
                    a_done_n = ctl_cmd_we;
                    b_done_n = ~ctl_cmd_we;
                end else if (ctl_cmd_ready) begin
                    state_n     = ctl_cmd_we ? WDATA : RDATA;
                    cmd_valid_n = 1'b0;
                    cnt_n       = '0;
                end
            end
            WDATA: begin
                if (beat_w) begin
                    if (cnt_q == last_beat) begin
                        state_n  = IDLE;
                        a_done_n = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_q + LEN_ONE;
                    end
                end
            end
            RDATA: begin
                if (beat_r) begin
                    if (cnt_q == last_beat) begin
                        state_n  = IDLE;
                        b_done_n = 1'b1;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_q + LEN_ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any burst immediately
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            last_b_q      <= 1'b1;
            cnt_q         <= '0;
            ctl_cmd_valid <= 1'b0;
            ctl_cmd_we    <= 1'b0;
            ctl_cmd_addr  <= '0;
            ctl_cmd_len   <= '0;
            a_gnt         <= 1'b0;
            b_gnt         <= 1'b0;
            a_done        <= 1'b0;
            b_done        <= 1'b0;
            busy          <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            state_q       <= state_n;
            last_b_q      <= last_b_n;
            cnt_q         <= cnt_n;
            ctl_cmd_valid <= cmd_valid_n;
            ctl_cmd_we    <= cmd_we_n;
            ctl_cmd_addr  <= cmd_addr_n;
            ctl_cmd_len   <= cmd_len_n;
            a_gnt         <= a_gnt_n;
            b_gnt         <= b_gnt_n;
            a_done        <= a_done_n;
            b_done        <= b_done_n;
            busy          <= (state_n != IDLE);
            proto_err     <= proto_err | (ctl_rvalid & ~in_rdata);
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Self-checking bench for ddr3_port_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_ddr3_port_arbiter;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 128;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          a_req, b_req;
    logic [AW-1:0] a_addr, b_addr;
    logic [LW-1:0] a_len, b_len;
    logic          a_gnt, b_gnt, a_done, b_done;
    logic [DW-1:0] a_wdata, b_rdata, ctl_wdata, ctl_rdata;
    logic          a_wvalid, a_wready, b_rvalid;
    logic          ctl_cmd_valid, ctl_cmd_ready, ctl_cmd_we;
    logic [AW-1:0] ctl_cmd_addr;
    logic [LW-1:0] ctl_cmd_len;
    logic          ctl_wvalid, ctl_wready, ctl_rvalid;
    logic          busy, proto_err;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .nrst(nrst),
        .a_req(a_req), .a_addr(a_addr), .a_len(a_len), .a_gnt(a_gnt),
        .a_wdata(a_wdata), .a_wvalid(a_wvalid), .a_wready(a_wready), .a_done(a_done),
        .b_req(b_req), .b_addr(b_addr), .b_len(b_len), .b_gnt(b_gnt),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_done(b_done),
        .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready), .ctl_cmd_we(ctl_cmd_we),
        .ctl_cmd_addr(ctl_cmd_addr), .ctl_cmd_len(ctl_cmd_len),
        .ctl_wdata(ctl_wdata), .ctl_wvalid(ctl_wvalid), .ctl_wready(ctl_wready),
        .ctl_rdata(ctl_rdata), .ctl_rvalid(ctl_rvalid),
        .busy(busy), .proto_err(proto_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0; a_len = '0; b_len = '0;
        a_wdata = '0; a_wvalid = 1'b0; ctl_cmd_ready = 1'b0; ctl_wready = 1'b0;
        ctl_rdata = '0; ctl_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        clr_inputs();
        repeat (3) @(posedge clk);
        #3 nrst = 1'b1;
        next_cyc();
    endtask

    // Directed vectors: inputs for one cycle and the expected flags
    // exp = {a_gnt, b_gnt, ctl_cmd_valid, fwd(ctl_wvalid & a_wready), a_done, b_done, busy}
    typedef struct packed {
        logic          a_req;
        logic          b_req;
        logic [LW-1:0] a_len;
        logic [LW-1:0] b_len;
        logic          a_wv;
        logic          cmd_rdy;
        logic          wrdy;
        logic [6:0]    exp;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic ar, input logic br, input logic [LW-1:0] al,
                        input logic [LW-1:0] bl, input logic wv, input logic cr,
                        input logic wr, input logic [6:0] e);
        vec_t v;
        v.a_req = ar; v.b_req = br; v.a_len = al; v.b_len = bl;
        v.a_wv = wv; v.cmd_rdy = cr; v.wrdy = wr; v.exp = e;
        vecs.push_back(v);
    endtask

    // Random-phase model state
    logic          m_last_b, a_pend, b_pend, act, port_b, done_pend, p_a, p_b, p_idle;
    logic          exp_ga, exp_gb, in_cmd, in_wd, in_rd;
    logic [LW-1:0] a_pl, b_pl, olen;
    logic [AW-1:0] a_pa, b_pa, oaddr;
    int            phase, beats, n_bur_a, n_bur_b;

    // Hand-sequence scratch
    int        ng, sent, got, ndone, done_k, last_k, na_sent, nc, derr, tail;
    int        gl[4];
    logic      rv;
    logic [DW-1:0] exp_data;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        clr_inputs();

        // ---------------- table: A write len 4, then B len 0 ----------------
        addv(1, 0, 8'd4, 8'd0, 1, 0, 1, 7'b0000000);
        addv(0, 0, 8'd4, 8'd0, 1, 1, 1, 7'b1010001);
        addv(0, 0, 8'd4, 8'd0, 1, 1, 1, 7'b0001001);
        addv(0, 0, 8'd4, 8'd0, 1, 1, 1, 7'b0001001);
        addv(0, 0, 8'd4, 8'd0, 1, 1, 1, 7'b0001001);
        addv(0, 0, 8'd4, 8'd0, 1, 1, 1, 7'b0001001);
        addv(0, 0, 8'd4, 8'd0, 1, 1, 1, 7'b0000100);
        addv(0, 1, 8'd0, 8'd0, 0, 0, 0, 7'b0000000);
        addv(0, 0, 8'd0, 8'd0, 0, 1, 0, 7'b0100001);
        addv(0, 0, 8'd0, 8'd0, 0, 1, 0, 7'b0000010);
        addv(0, 0, 8'd0, 8'd0, 0, 0, 0, 7'b0000000);

        do_reset();
        chk("reset_flags", {a_gnt, b_gnt, ctl_cmd_valid, a_done, b_done, busy, proto_err}, 7'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            a_req = vecs[i].a_req; b_req = vecs[i].b_req;
            a_len = vecs[i].a_len; b_len = vecs[i].b_len;
            a_addr = 24'h000100; b_addr = 24'h000200;
            a_wvalid = vecs[i].a_wv; ctl_cmd_ready = vecs[i].cmd_rdy; ctl_wready = vecs[i].wrdy;
            a_wdata = {4{32'hA5A5_0000 + 32'(i)}};
            #1;
            chk($sformatf("vec%0d_flags", i),
                {a_gnt, b_gnt, ctl_cmd_valid, ctl_wvalid, a_wready, a_done, b_done, busy},
                {vecs[i].exp[6:4], vecs[i].exp[3], vecs[i].exp[3], vecs[i].exp[2:0]});
            chk($sformatf("vec%0d_wdata", i), ctl_wdata, vecs[i].exp[3] ? a_wdata : 128'h0);
            if (vecs[i].exp[4])
                chk($sformatf("vec%0d_cmd", i), {ctl_cmd_we, ctl_cmd_addr, ctl_cmd_len},
                    {1'b1, 24'h000100, 8'd4});
            next_cyc();
        end

        // ---------------- both held: grants alternate starting with A ----------------
        do_reset();
        a_req = 1'b1; b_req = 1'b1; a_len = '0; b_len = '0;
        ng = 0;
        for (int i = 0; i < 4; i++) gl[i] = 9;
        for (int k = 0; k < 20 && ng < 4; k++) begin
            #1;
            if (a_gnt && ng < 4) begin gl[ng] = 0; ng++; end
            if (b_gnt && ng < 4) begin gl[ng] = 1; ng++; end
            next_cyc();
        end
        a_req = 1'b0; b_req = 1'b0;
        repeat (3) next_cyc();
        chk("rr_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(gl[i]), 32'(i % 2));

        // ---------------- B read len 8, command stalled 5 cycles, gappy beats ----------------
        b_req = 1'b1; b_addr = 24'h00ABCD; b_len = 8'd8;
        next_cyc();
        b_req = 1'b0; ctl_cmd_ready = 1'b0;
        #1;
        chk("b8_gnt", {a_gnt, b_gnt}, 2'b01);
        for (int k = 0; k < 5; k++) begin
            chk("b8_cmd_hold", {ctl_cmd_valid, ctl_cmd_we, ctl_cmd_addr, ctl_cmd_len},
                {1'b1, 1'b0, 24'h00ABCD, 8'd8});
            next_cyc();
            #1;
        end
        ctl_cmd_ready = 1'b1;
        chk("b8_cmd_hs", {ctl_cmd_valid, ctl_cmd_we, ctl_cmd_addr, ctl_cmd_len},
            {1'b1, 1'b0, 24'h00ABCD, 8'd8});
        next_cyc();
        ctl_cmd_ready = 1'b0;
        sent = 0; got = 0; ndone = 0; done_k = -1; last_k = -1;
        for (int k = 0; k < 40; k++) begin
            if (b_done) begin ndone++; done_k = k; end
            rv = (sent < 8) && (k % 3 != 1);
            ctl_rvalid = rv;
            ctl_rdata = {4{32'hD000_0000 + 32'(sent)}};
            #1;
            chk("b8_rvalid", b_rvalid, rv);
            if (b_rvalid) begin
                exp_data = {4{32'hD000_0000 + 32'(got)}};
                chk("b8_rdata", b_rdata, exp_data);
                got++;
                last_k = k;
            end
            if (rv) sent++;
            next_cyc();
        end
        ctl_rvalid = 1'b0;
        chk("b8_beats", 32'(got), 32'd8);
        chk("b8_done_once", 32'(ndone), 32'd1);
        chk("b8_done_time", 32'(done_k), 32'(last_k + 1));
        chk("b8_no_err", proto_err, 1'b0);

        // ---------------- stray read beat while idle ----------------
        clr_inputs();
        next_cyc();
        chk("proto_pre", proto_err, 1'b0);
        ctl_rvalid = 1'b1; ctl_rdata = '1;
        #1;
        chk("proto_drop", {b_rvalid, b_rdata}, 129'h0);
        next_cyc();
        ctl_rvalid = 1'b0;
        chk("proto_set", proto_err, 1'b1);
        repeat (5) next_cyc();
        chk("proto_sticky", proto_err, 1'b1);

        // ---------------- reset in the middle of a 6-beat write ----------------
        a_req = 1'b1; a_addr = 24'h123456; a_len = 8'd6;
        next_cyc();
        a_req = 1'b0; ctl_cmd_ready = 1'b1; a_wvalid = 1'b1; ctl_wready = 1'b1;
        a_wdata = {4{32'hCAFE_F00D}};
        beats = 0;
        for (int k = 0; k < 12 && beats < 2; k++) begin
            #1;
            if (ctl_wvalid && ctl_wready) beats++;
            next_cyc();
        end
        chk("rst_mid_beats", 32'(beats), 32'd2);
        #2;
        nrst = 1'b0;
        ctl_rvalid = 1'b1; ctl_rdata = '1;
        #1;
        chk("rst_mid_flags", {a_gnt, a_wready, a_done, b_gnt, b_rvalid, b_done, ctl_cmd_valid,
                              ctl_cmd_we, ctl_cmd_addr, ctl_cmd_len, ctl_wvalid, busy, proto_err}, 0);
        chk("rst_mid_wdata", ctl_wdata, 128'h0);
        chk("rst_mid_rdata", b_rdata, 128'h0);
        do_reset();

        // ---------------- maximum-length write after reset ----------------
        a_req = 1'b1; a_addr = 24'h000000; a_len = 8'd255;
        next_cyc();
        a_req = 1'b0;
        chk("l255_gnt", a_gnt, 1'b1);
        na_sent = 0; nc = 0; derr = 0; ndone = 0; tail = 0;
        for (int k = 0; k < 2000; k++) begin
            if (a_done) ndone++;
            if (ndone != 0) tail++;
            if (tail > 3) break;
            ctl_cmd_ready = 1'b1;
            ctl_wready = 1'($urandom_range(1));
            a_wvalid = (na_sent < 255) && ($urandom_range(1) == 1);
            a_wdata = 128'(na_sent);
            #1;
            if (ctl_wvalid && ctl_wready) begin
                if (ctl_wdata !== 128'(nc)) derr++;
                nc++;
            end
            if (a_wvalid && a_wready) na_sent++;
            next_cyc();
        end
        chk("l255_beats", 32'(nc), 32'd255);
        chk("l255_data", 32'(derr), 32'd0);
        chk("l255_done_once", 32'(ndone), 32'd1);

        // ---------------- randomized traffic against transaction model ----------------
        do_reset();
        m_last_b = 1'b1; a_pend = 1'b0; b_pend = 1'b0; act = 1'b0; port_b = 1'b0;
        done_pend = 1'b0; p_a = 1'b0; p_b = 1'b0; p_idle = 1'b1;
        a_pl = '0; b_pl = '0; a_pa = '0; b_pa = '0; olen = '0; oaddr = '0;
        phase = 0; beats = 0; n_bur_a = 0; n_bur_b = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_ga = p_idle & p_a & (~p_b | m_last_b);
            exp_gb = p_idle & p_b & (~p_a | ~m_last_b);
            chk("rnd_gnt", {a_gnt, b_gnt}, {exp_ga, exp_gb});
            chk("rnd_done", {a_done, b_done}, {done_pend & ~port_b, done_pend & port_b});
            if (done_pend) begin
                act = 1'b0;
                if (port_b) n_bur_b++; else n_bur_a++;
            end
            done_pend = 1'b0;
            if (exp_ga || exp_gb) begin
                act = 1'b1; port_b = exp_gb; m_last_b = exp_gb; beats = 0;
                olen  = exp_gb ? b_pl : a_pl;
                oaddr = exp_gb ? b_pa : a_pa;
                if (exp_ga) a_pend = 1'b0; else b_pend = 1'b0;
                if (olen == '0) begin phase = 2; done_pend = 1'b1; end
                else phase = 0;
            end
            chk("rnd_busy", busy, act);
            if (!a_pend && !(act && !port_b) && $urandom_range(3) == 0) begin
                a_pend = 1'b1; a_pl = 8'($urandom_range(9)); a_pa = 24'($urandom);
            end
            if (!b_pend && !(act && port_b) && $urandom_range(3) == 0) begin
                b_pend = 1'b1; b_pl = 8'($urandom_range(9)); b_pa = 24'($urandom);
            end
            a_req = a_pend; a_len = a_pl; a_addr = a_pa;
            b_req = b_pend; b_len = b_pl; b_addr = b_pa;
            in_cmd = act && (phase == 0);
            in_wd  = act && (phase == 1) && !port_b;
            in_rd  = act && (phase == 1) && port_b;
            ctl_cmd_ready = 1'($urandom_range(1));
            ctl_wready    = 1'($urandom_range(1));
            a_wvalid      = 1'($urandom_range(1));
            a_wdata       = {$urandom, $urandom, $urandom, $urandom};
            ctl_rvalid    = in_rd && ($urandom_range(2) != 0);
            ctl_rdata     = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("rnd_cmd", {ctl_cmd_valid, in_cmd ? {ctl_cmd_we, ctl_cmd_addr, ctl_cmd_len} : 33'h0},
                {in_cmd, in_cmd ? {~port_b, oaddr, olen} : 33'h0});
            chk("rnd_wr", {ctl_wvalid, a_wready, ctl_wdata},
                {in_wd & a_wvalid, in_wd & ctl_wready, in_wd ? a_wdata : 128'h0});
            chk("rnd_rd", {b_rvalid, b_rdata}, {in_rd & ctl_rvalid, in_rd ? ctl_rdata : 128'h0});
            if (in_cmd && ctl_cmd_ready) begin
                phase = 1; beats = 0;
            end else if ((in_wd && a_wvalid && ctl_wready) || (in_rd && ctl_rvalid)) begin
                beats++;
                if (beats == int'(olen)) begin phase = 2; done_pend = 1'b1; end
            end
            p_a = a_req; p_b = b_req; p_idle = !act;
            next_cyc();
        end
        chk("rnd_proto_clean", proto_err, 1'b0);
        chk("rnd_bursts_a", n_bur_a > 10, 1'b1);
        chk("rnd_bursts_b", n_bur_b > 10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
